// File: rtl/bg_vga_pkg.sv
// Shared scroll-state encoding and palette for the scrolling background generator.
package bg_vga_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StScroll = 2'd1,
    StFrozen = 2'd2
  } scroll_state_e;

  localparam logic [2:0] SKY_RGB      = 3'b010;
  localparam logic [2:0] GROUND_A_RGB = 3'b001;
  localparam logic [2:0] GROUND_B_RGB = 3'b000;
  localparam logic [2:0] EDGE_RGB     = 3'b110;

endpackage

// File: rtl/bg_scroll_ctrl.sv
// Scroll state machine (IDLE/SCROLL/FROZEN) and the per-frame ground stripe offset register.
module bg_scroll_ctrl
  import bg_vga_pkg::*;
#(
  parameter int unsigned X_W         = 9,
  parameter int unsigned STRIPE_W    = 16,
  parameter int unsigned SCROLL_STEP = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_start,
  input  logic           run,
  input  logic           halt,
  output logic [X_W-1:0] scroll_offset
);

  localparam logic [X_W:0] PeriodMask = (X_W + 1)'(2 * STRIPE_W - 1);
  localparam logic [X_W:0] Step       = (X_W + 1)'(SCROLL_STEP);

  scroll_state_e  state_q, state_d;
  logic [X_W-1:0] offset_q, offset_d;
  logic [X_W:0]   offset_sum;

  assign offset_sum = ({1'b0, offset_q} + Step) & PeriodMask;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (halt)     state_d = StFrozen;
        else if (run) state_d = StScroll;
      end
      StScroll: begin
        if (halt)      state_d = StFrozen;
        else if (!run) state_d = StIdle;
      end
      StFrozen: begin
        if (!halt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Offset is pinned to zero in IDLE and on any entry to IDLE; it only moves while
  // remaining in SCROLL, so a FRAME_START coinciding with IDLE->SCROLL or HALT is ignored.
  always_comb begin
    offset_d = offset_q;
    if (state_q == StIdle || state_d == StIdle) begin
      offset_d = '0;
    end else if (state_q == StScroll && state_d == StScroll && frame_start) begin
      offset_d = offset_sum[X_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
    end
  end

  assign scroll_offset = offset_q;

endmodule

// File: rtl/background_scroll_vga.sv
// Sky/ground background with a scrolling two-tone ground stripe and registered RGB output.
// Optional grass-edge band above the stripes is enabled by defining BG_GRASS_EDGE_EN.
module background_scroll_vga
  import bg_vga_pkg::*;
#(
  parameter int unsigned X_W          = 9,
  parameter int unsigned Y_W          = 8,
  parameter int unsigned GROUND_START = 230,
  parameter int unsigned STRIPE_W     = 16,
  parameter int unsigned SCROLL_STEP  = 2,
  parameter int unsigned EDGE_H       = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           pix_valid,
  input  logic           frame_start,
  input  logic           run,
  input  logic           halt,
  output logic [2:0]     rgb,
  output logic           rgb_valid,
  output logic [X_W-1:0] scroll_offset
);

`ifdef BG_GRASS_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  localparam int unsigned  EdgeRows   = EdgeEn ? EDGE_H : 0;
  localparam int unsigned  EdgeEnd    = GROUND_START + EdgeRows;
  localparam logic [X_W:0] PeriodMask = (X_W + 1)'(2 * STRIPE_W - 1);
  localparam logic [X_W:0] StripeW    = (X_W + 1)'(STRIPE_W);

  logic [X_W-1:0] offset;
  logic [X_W:0]   phase;
  logic [31:0]    y_ext;
  logic           is_ground, in_edge;
  logic [2:0]     rgb_q, rgb_d;
  logic           rgb_valid_q, rgb_valid_d;

  bg_scroll_ctrl #(
    .X_W        (X_W),
    .STRIPE_W   (STRIPE_W),
    .SCROLL_STEP(SCROLL_STEP)
  ) u_scroll_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .run          (run),
    .halt         (halt),
    .scroll_offset(offset)
  );

  // Row compares run 32 bits wide so GROUND_START + EDGE_H can never wrap and a
  // GROUND_START past the Y range simply yields an all-sky frame.
  assign y_ext     = 32'(y);
  assign is_ground = (y_ext >= GROUND_START);
  assign in_edge   = is_ground && (y_ext < EdgeEnd);
  assign phase     = ({1'b0, x} + {1'b0, offset}) & PeriodMask;

  always_comb begin
    rgb_d       = 3'b000;
    rgb_valid_d = 1'b0;
    if (pix_valid) begin
      rgb_valid_d = 1'b1;
      if (!is_ground) begin
        rgb_d = SKY_RGB;
      end else if (in_edge) begin
        rgb_d = EDGE_RGB;
      end else if (phase < StripeW) begin
        rgb_d = GROUND_A_RGB;
      end else begin
        rgb_d = GROUND_B_RGB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q       <= 3'b000;
      rgb_valid_q <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      rgb_valid_q <= rgb_valid_d;
    end
  end

  assign rgb           = rgb_q;
  assign rgb_valid     = rgb_valid_q;
  assign scroll_offset = offset;

endmodule

// File: tb/tb_background_scroll_vga.sv
// Directed bench for background_scroll_vga: reset, pixel colours, scroll FSM and offset wrap.
module tb_background_scroll_vga;

  logic       clk;
  logic       rst_n;
  logic [8:0] x;
  logic [7:0] y;
  logic       pix_valid;
  logic       frame_start;
  logic       run;
  logic       halt;
  logic [2:0] rgb;
  logic       rgb_valid;
  logic [8:0] scroll_offset;

  int n_tests = 0;
  int n_fail  = 0;

  background_scroll_vga #(
    .X_W         (9),
    .Y_W         (8),
    .GROUND_START(230),
    .STRIPE_W    (16),
    .SCROLL_STEP (2),
    .EDGE_H      (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .y            (y),
    .pix_valid    (pix_valid),
    .frame_start  (frame_start),
    .run          (run),
    .halt         (halt),
    .rgb          (rgb),
    .rgb_valid    (rgb_valid),
    .scroll_offset(scroll_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; x = '0; y = '0; pix_valid = 1'b1;
    frame_start = 1'b0; run = 1'b0; halt = 1'b0;
    tick(); tick();
    n_tests++;
    if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_rgb got %b want 000", rgb); end
    n_tests++;
    if (rgb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rgb_valid); end
    n_tests++;
    if (scroll_offset !== 9'd0) begin
      n_fail++; $display("FAIL reset_offset got %0d want 0", scroll_offset);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pixel_idle();
    pix_valid = 1'b1; y = 8'd229; x = 9'd5;
    tick();
    n_tests++;
    if (rgb !== 3'b010 || rgb_valid !== 1'b1) begin
      n_fail++; $display("FAIL idle_sky got %b/%b want 010/1", rgb, rgb_valid);
    end
    y = 8'd230; x = 9'd0;
    tick();
    n_tests++;
    if (rgb !== 3'b001) begin n_fail++; $display("FAIL idle_ground_a got %b want 001", rgb); end
    x = 9'd16;
    tick();
    n_tests++;
    if (rgb !== 3'b000 || rgb_valid !== 1'b1) begin
      n_fail++; $display("FAIL idle_ground_b got %b/%b want 000/1", rgb, rgb_valid);
    end
    pix_valid = 1'b0; y = 8'd100;
    tick();
    n_tests++;
    if (rgb !== 3'b000 || rgb_valid !== 1'b0) begin
      n_fail++; $display("FAIL blank got %b/%b want 000/0", rgb, rgb_valid);
    end
  endtask

  task automatic test_scroll_wrap();
    logic [8:0] exp_off;
    // FRAME_START together with IDLE->SCROLL must not advance
    run = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_tests++;
    if (scroll_offset !== 9'd0) begin
      n_fail++; $display("FAIL entry_no_advance got %0d want 0", scroll_offset);
    end
    exp_off = 9'd0;
    for (int k = 1; k <= 15; k++) begin
      pulse_frame();
      exp_off = (exp_off + 9'd2) & 9'd31;
      n_tests++;
      if (scroll_offset !== exp_off) begin
        n_fail++; $display("FAIL offset_step%0d got %0d want %0d", k, scroll_offset, exp_off);
      end
    end
    pix_valid = 1'b1; y = 8'd230; x = 9'd2;
    tick();
    n_tests++;
    if (rgb !== 3'b001) begin n_fail++; $display("FAIL off30_x2 got %b want 001", rgb); end
    x = 9'd1;
    tick();
    n_tests++;
    if (rgb !== 3'b000) begin n_fail++; $display("FAIL off30_x1 got %b want 000", rgb); end
    x = 9'd17;
    tick();
    n_tests++;
    if (rgb !== 3'b001) begin n_fail++; $display("FAIL off30_x17 got %b want 001", rgb); end
    pulse_frame();
    n_tests++;
    if (scroll_offset !== 9'd0) begin
      n_fail++; $display("FAIL offset_wrap got %0d want 0", scroll_offset);
    end
  endtask

  task automatic test_freeze();
    pulse_frame(); pulse_frame();
    n_tests++;
    if (scroll_offset !== 9'd4) begin
      n_fail++; $display("FAIL pre_freeze got %0d want 4", scroll_offset);
    end
    halt = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    n_tests++;
    if (scroll_offset !== 9'd4) begin
      n_fail++; $display("FAIL halt_with_frame got %0d want 4", scroll_offset);
    end
    pulse_frame(); tick();
    n_tests++;
    if (scroll_offset !== 9'd4) begin
      n_fail++; $display("FAIL frozen_hold got %0d want 4", scroll_offset);
    end
    halt = 1'b0;
    tick();
    n_tests++;
    if (scroll_offset !== 9'd0) begin
      n_fail++; $display("FAIL unfreeze_idle got %0d want 0", scroll_offset);
    end
    tick();
    pulse_frame();
    n_tests++;
    if (scroll_offset !== 9'd2) begin
      n_fail++; $display("FAIL rescroll got %0d want 2", scroll_offset);
    end
  endtask

  task automatic test_run_drop();
    run = 1'b0;
    tick();
    n_tests++;
    if (scroll_offset !== 9'd0) begin
      n_fail++; $display("FAIL run_drop got %0d want 0", scroll_offset);
    end
    pulse_frame();
    n_tests++;
    if (scroll_offset !== 9'd0) begin
      n_fail++; $display("FAIL idle_frame got %0d want 0", scroll_offset);
    end
  endtask

  task automatic test_edge();
    pix_valid = 1'b1;
`ifdef BG_GRASS_EDGE_EN
    for (int r = 230; r <= 233; r++) begin
      y = 8'(r); x = 9'd0;
      tick();
      n_tests++;
      if (rgb !== 3'b110) begin n_fail++; $display("FAIL edge_row%0d got %b want 110", r, rgb); end
    end
    run = 1'b1;
    tick();
    pulse_frame(); pulse_frame(); pulse_frame();
    y = 8'd231; x = 9'd20;
    tick();
    n_tests++;
    if (rgb !== 3'b110) begin n_fail++; $display("FAIL edge_off6 got %b want 110", rgb); end
    y = 8'd234; x = 9'd0;
    tick();
    n_tests++;
    if (rgb !== 3'b001) begin n_fail++; $display("FAIL below_edge got %b want 001", rgb); end
`else
    y = 8'd233; x = 9'd16;
    tick();
    n_tests++;
    if (rgb !== 3'b000) begin n_fail++; $display("FAIL no_edge_b got %b want 000", rgb); end
    x = 9'd15;
    tick();
    n_tests++;
    if (rgb !== 3'b001) begin n_fail++; $display("FAIL no_edge_a got %b want 001", rgb); end
    y = 8'd255; x = 9'd31;
    tick();
    n_tests++;
    if (rgb !== 3'b000) begin n_fail++; $display("FAIL bottom_row got %b want 000", rgb); end
`endif
  endtask

  task automatic test_reset_midframe();
    run = 1'b1;
    tick();
    pulse_frame(); pulse_frame();
    pix_valid = 1'b1; y = 8'd100; x = 9'd7;
    tick();
    n_tests++;
    if (rgb !== 3'b010 || scroll_offset === 9'd0) begin
      n_fail++; $display("FAIL pre_reset got %b/%0d want 010/nonzero", rgb, scroll_offset);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (rgb !== 3'b000 || rgb_valid !== 1'b0 || scroll_offset !== 9'd0) begin
      n_fail++;
      $display("FAIL async_reset got %b/%b/%0d want 000/0/0", rgb, rgb_valid, scroll_offset);
    end
    tick();
    rst_n = 1'b1;
    run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_pixel_idle();
    test_scroll_wrap();
    test_freeze();
    test_run_drop();
    test_edge();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
